cronometro_ctrl: RTL and testbench
==================================

# cronometro_ctrl

Run/pause/clear controller for a cascade of mod-10 digit counters, forming a multi-digit BCD stopwatch. A clock prescaler generates count ticks. A four-state FSM gates the ticks and sequences the digit chain. A terminal condition halts the chain at all-nines. The block sits above the existing mod-10 counter datapath and replaces free-running counting with commanded counting.

## Interface
- DIGITS, default 4: number of cascaded BCD digits. Must be ≥ 1.
- TICK_DIV, default 10: clk cycles per count tick. Must be ≥ 2.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous reset, active-low.
- start_stop  input  1  single-cycle command pulse: start, pause or resume.
- clear  input  1  single-cycle command pulse: return to zero and IDLE.
- q  output  4*DIGITS  BCD count; digit 0 (least significant) is in q[3:0].
- running  output  1  high while the state is RUN.
- done  output  1  high while the state is DONE.

## Operation
- States:
  - IDLE: count is zero.
  - RUN: counting.
  - PAUSE: count frozen.
  - DONE: count saturated at all-nines.
- Transitions, evaluated at each rising edge:
  - IDLE → RUN on start_stop.
  - RUN → PAUSE on start_stop.
  - PAUSE → RUN on start_stop.
  - RUN → DONE on a tick when every digit is 9.
  - Any state → IDLE on clear.
- start_stop is ignored in DONE. Only clear or reset leaves DONE.
- Priority, highest first: reset, then clear, then the DONE transition, then start_stop.
- Prescaler:
  - Counts 0..TICK_DIV-1, and only in RUN.
  - tick = (state==RUN) and (prescaler==TICK_DIV-1).
  - The prescaler wraps to 0 on the tick edge.
  - The prescaler holds its value in PAUSE, so resume continues the partial period.
  - Clear and reset zero the prescaler.
- Digit chain:
  - Digit 0 is enabled by tick.
  - Digit k is enabled by (enable of digit k-1) and (digit k-1 == 9).
  - An enabled digit goes 9 → 0, otherwise it increments.
- All-nines at a tick: the digits hold 9 (no wrap to zero) and the state enters DONE.
- start_stop in the same cycle as a tick in RUN: the increment happens and the state moves to PAUSE on the same edge.
- clear and start_stop in the same cycle: clear wins and the state goes to IDLE.
- Widths:
  - Prescaler is $clog2(TICK_DIV) bits.
  - Each digit is 4 bits and never takes values 10–15.

## Timing
- Reset (reset==0 at an edge): q=0, running=0, done=0, prescaler=0, state=IDLE, all from that edge onward.
- Reset is sampled only at clock edges. A low glitch between edges has no effect.
- Command latency: one cycle. start_stop sampled at edge n → running=1 after edge n.
- First increment: TICK_DIV cycles after RUN is entered from IDLE.
- Steady-state increment period while in RUN: exactly TICK_DIV cycles.
- Outputs are registered or decoded from registered state only. There is no combinational path from an input to an output.
- The full count of 10^DIGITS − 1 is reached after 10^DIGITS − 1 ticks. done rises on the following tick edge.

## Structure
- Shared package cronometro_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Constant BCD_MAX = 4'd9.
  - Function all_nines(q) for the terminal test.
- Sub-module bcd_digit, instantiated DIGITS times via generate:
  - Ports: clk, reset (sync, active-low), en, clr, q[3:0], carry.
  - carry = en and q==9.
- The top level holds the FSM, the prescaler and the all-nines detect.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4.
- Reset: hold reset=0 for 3 cycles with random start_stop/clear → q=8'h00, running=0, done=0 throughout.
- Count: pulse start_stop, then wait 40 cycles → running=1 from the next edge; q=8'h01 at cycle 4; q=8'h10 at cycle 40; digit 1 increments exactly when digit 0 goes 9 → 0.
- Pause/resume:
  - Pause when q=8'h05 and prescaler=2, then hold 20 cycles → q stays 8'h05 and running=0.
  - Pulse start_stop again → q=8'h06 exactly 2 cycles after resume.
- Saturation:
  - Run to q=8'h99; on the next tick → done=1, running=0, q stays 8'h99.
  - start_stop in DONE → no change.
  - clear → q=8'h00, done=0, state IDLE.
- Simultaneous events:
  - clear+start_stop in the same cycle during RUN → IDLE, q=8'h00.
  - start_stop coincident with a tick at q=8'h19 → q=8'h20 and PAUSE.
- Mid-run reset: reset low for one edge at q=8'h37 → q=8'h00 and running=0 after that edge; after reset is released, a start_stop pulse restarts counting from 8'h00.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared types and helpers for the BCD stopwatch controller.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Upper bound on digit count accepted by all_nines; callers zero-extend.
    localparam int unsigned MAX_DIGITS = 16;

    function automatic logic all_nines(input logic [4*MAX_DIGITS-1:0] q,
                                       input int unsigned             n);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && q[4*i +: 4] != BCD_MAX) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 digit of the stopwatch chain; carry enables the next digit.
module bcd_digit
    import cronometro_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q     = q_q;
    assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/cronometro_ctrl.sv
// Run/pause/clear controller for a DIGITS-wide BCD stopwatch: FSM, tick
// prescaler and all-nines saturation around a cascade of bcd_digit counters.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_stop,
    input  logic                clear,
    output logic [4*DIGITS-1:0] q,
    output logic                running,
    output logic                done
);

    localparam int unsigned     PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    state_t                 state_q, state_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic                   tick;
    logic                   full;
    logic [4*DIGITS-1:0]    q_w;
    logic [4*MAX_DIGITS-1:0] q_ext;
    logic [DIGITS:0]        en_chain;
    logic                   chain_unused;

    assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

    always_comb begin
        q_ext              = '0;
        q_ext[4*DIGITS-1:0] = q_w;
    end

    assign full = all_nines(q_ext, DIGITS);

    // Gating the chain with !full keeps all-nines frozen instead of wrapping.
    assign en_chain[0]  = tick && !full;
    assign chain_unused = en_chain[DIGITS];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .en    (en_chain[k]),
            .clr   (clear),
            .q     (q_w[4*k +: 4]),
            .carry (en_chain[k+1])
        );
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        if (clear) begin
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE:  if (start_stop) state_d = RUN;
                RUN: begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick && full)    state_d = DONE;
                    else if (start_stop) state_d = PAUSE;
                end
                PAUSE: if (start_stop) state_d = RUN;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end

    assign q       = q_w;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl (DIGITS=2, TICK_DIV=4) with an
// integer-count reference model checked every cycle.
module tb_cronometro_ctrl;

    localparam int unsigned DIG  = 2;
    localparam int unsigned TD   = 4;
    localparam int          MAXC = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] q;
    logic       running;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    mstate_t m_st    = M_IDLE;
    int      m_cnt   = 0;
    int      m_pre   = 0;
    bit      m_valid = 1'b0;

    cronometro_ctrl #(.DIGITS(DIG), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .q          (q),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input int c);
        logic [3:0] lo, hi;
        lo = 4'(c % 10);
        hi = 4'((c / 10) % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count is a plain integer, digits are derived by division.
    always @(posedge clk) begin
        if (!reset) begin
            m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_valid = 1'b1;
        end else if (clear) begin
            m_st = M_IDLE; m_cnt = 0; m_pre = 0;
        end else begin
            case (m_st)
                M_IDLE:  if (start_stop) m_st = M_RUN;
                M_PAUSE: if (start_stop) m_st = M_RUN;
                M_RUN: begin
                    if (m_pre == TD - 1) begin
                        m_pre = 0;
                        if (m_cnt == MAXC) m_st = M_DONE;
                        else begin
                            m_cnt++;
                            if (start_stop) m_st = M_PAUSE;
                        end
                    end else begin
                        m_pre++;
                        if (start_stop) m_st = M_PAUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_q",       32'(q),       32'(bcd2(m_cnt)));
            check("model_running", 32'(running), 32'(m_st == M_RUN));
            check("model_done",    32'(done),    32'(m_st == M_DONE));
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; cycles(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cycles(1); clear = 1'b0;
    endtask

    initial begin
        // Reset held with random commands
        repeat (3) begin
            start_stop = 1'($urandom_range(0, 1));
            clear      = 1'($urandom_range(0, 1));
            cycles(1);
            check("rst_q", 32'(q), 32'h00);
            check("rst_running", 32'(running), 0);
            check("rst_done", 32'(done), 0);
        end
        start_stop = 1'b0; clear = 1'b0; reset = 1'b1;
        cycles(2);
        check("idle_q", 32'(q), 32'h00);

        // Count, with a reset glitch between edges that must be ignored
        pulse_ss();
        check("start_running", 32'(running), 1);
        reset = 1'b0; #2; reset = 1'b1;
        cycles(3);
        check("count_c3", 32'(q), 32'h00);
        cycles(1);
        check("count_c4", 32'(q), 32'h01);
        cycles(36);
        check("count_c40", 32'(q), 32'h10);
        check("count_running", 32'(running), 1);

        // Pause with prescaler frozen at 2, then resume
        pulse_clear();
        check("clr_q", 32'(q), 32'h00);
        check("clr_running", 32'(running), 0);
        pulse_ss();
        cycles(21);
        check("pre_pause_q", 32'(q), 32'h05);
        pulse_ss();
        check("pause_running", 32'(running), 0);
        cycles(20);
        check("pause_hold_q", 32'(q), 32'h05);
        check("pause_hold_running", 32'(running), 0);
        pulse_ss();
        check("resume_running", 32'(running), 1);
        check("resume_q0", 32'(q), 32'h05);
        cycles(1);
        check("resume_q1", 32'(q), 32'h05);
        cycles(1);
        check("resume_q2", 32'(q), 32'h06);

        // Saturation at all-nines
        pulse_clear();
        pulse_ss();
        cycles(396);
        check("sat_q99", 32'(q), 32'h99);
        check("sat_running", 32'(running), 1);
        cycles(4);
        check("sat_done", 32'(done), 1);
        check("sat_not_running", 32'(running), 0);
        check("sat_hold_q", 32'(q), 32'h99);
        pulse_ss();
        cycles(5);
        check("done_ignores_ss", 32'(done), 1);
        check("done_q", 32'(q), 32'h99);
        pulse_clear();
        check("done_clr_q", 32'(q), 32'h00);
        check("done_clr_done", 32'(done), 0);

        // clear and start_stop together during RUN
        pulse_ss();
        cycles(10);
        start_stop = 1'b1; clear = 1'b1;
        cycles(1);
        start_stop = 1'b0; clear = 1'b0;
        check("clr_ss_q", 32'(q), 32'h00);
        check("clr_ss_running", 32'(running), 0);

        // start_stop on the tick edge at 19
        pulse_ss();
        cycles(79);
        check("pre_tick_q", 32'(q), 32'h19);
        pulse_ss();
        check("ss_tick_q", 32'(q), 32'h20);
        check("ss_tick_running", 32'(running), 0);
        cycles(8);
        check("ss_tick_hold_q", 32'(q), 32'h20);

        // Mid-run reset at 37
        pulse_clear();
        pulse_ss();
        cycles(148);
        check("pre_rst_q", 32'(q), 32'h37);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_running", 32'(running), 0);
        cycles(2);
        check("midrst_idle_q", 32'(q), 32'h00);
        pulse_ss();
        cycles(4);
        check("restart_q", 32'(q), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
